// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory port, one request in flight.
// Data has priority; a saturating starvation counter eventually forces an inst grant.
//
// state | meaning
// IDLE  | no request in flight; grant one requester combinationally
// ISSUE | mem_req_valid high with latched fields until mem_req_ready
// WAIT  | request accepted by memory; waiting for mem_rsp_valid
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req_valid,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  output logic                inst_req_ready,
  output logic                inst_rsp_valid,
  output logic [DATA_W-1:0]   inst_rsp_data,
  input  logic                data_req_valid,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic [DATA_W-1:0]   data_req_wdata,
  input  logic [DATA_W/8-1:0] data_req_wstrb,
  output logic                data_req_ready,
  output logic                data_rsp_valid,
  output logic [DATA_W-1:0]   data_rsp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int SW = DATA_W / 8;
  localparam int CW = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            owner_data;
  logic            inst_first;
  logic            grant_inst;
  logic            grant_data;
  logic            issue;

  // Grants are gated by reset so the ready outputs stay low while reset is held.
  always_comb begin
    inst_first = inst_req_valid && (starve_cnt == STARVE_TOP);
    grant_data = reset && (state == IDLE) && data_req_valid && !inst_first;
    grant_inst = reset && (state == IDLE) && inst_req_valid && !grant_data;
  end

  assign inst_req_ready = grant_inst;
  assign data_req_ready = grant_data;
  assign issue          = (state == ISSUE);
  assign mem_req_valid  = issue;
  assign mem_req_addr   = issue ? addr_q  : '0;
  assign mem_req_wdata  = issue ? wdata_q : '0;
  assign mem_req_wstrb  = issue ? wstrb_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      owner_data     <= 1'b0;
      inst_rsp_valid <= 1'b0;
      inst_rsp_data  <= '0;
      data_rsp_valid <= 1'b0;
      data_rsp_data  <= '0;
    end else begin
      inst_rsp_valid <= 1'b0;
      inst_rsp_data  <= '0;
      data_rsp_valid <= 1'b0;
      data_rsp_data  <= '0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            addr_q     <= data_req_addr;
            wdata_q    <= data_req_wdata;
            wstrb_q    <= data_req_wstrb;
            owner_data <= 1'b1;
            state      <= ISSUE;
            if (inst_req_valid && (starve_cnt != STARVE_TOP))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_inst) begin
            addr_q     <= inst_req_addr;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            owner_data <= 1'b0;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (owner_data) begin
              data_rsp_valid <= 1'b1;
              data_rsp_data  <= (wstrb_q == '0) ? mem_rsp_data : '0;
            end else begin
              inst_rsp_valid <= 1'b1;
              inst_rsp_data  <= mem_rsp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (one outstanding request, sparse memory, starvation count).
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req_valid, inst_req_ready, inst_rsp_valid;
  logic [31:0] inst_req_addr, inst_rsp_data;
  logic        data_req_valid, data_req_ready, data_rsp_valid;
  logic [31:0] data_req_addr, data_req_wdata, data_rsp_data;
  logic [3:0]  data_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
    .inst_req_ready(inst_req_ready), .inst_rsp_valid(inst_rsp_valid),
    .inst_rsp_data(inst_rsp_data),
    .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
    .data_req_wdata(data_req_wdata), .data_req_wstrb(data_req_wstrb),
    .data_req_ready(data_req_ready), .data_rsp_valid(data_rsp_valid),
    .data_rsp_data(data_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        own_d;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
  } req_t;

  int tests = 0;
  int fails = 0;

  // requester masters
  logic        iv = 0, dv = 0;
  logic [31:0] ia = 0, da = 0, dw = 0;
  logic [3:0]  ds = 0;
  int          imode = 0, dmode = 0;

  // memory responder
  logic [31:0] mem [logic [31:0]];
  int          rdy_rand = 0, hold_n = 0, lat_cfg = 0, lat = 0, spur_rand = 0;
  logic        spur = 0;
  logic [31:0] pend_rdata = 0;

  // arbiter model
  logic        busy = 0, accepted = 0, rsp_due = 0, rsp_own_d = 0;
  logic [31:0] rsp_dat = 0;
  int          starve = 0;
  req_t        pend;

  // observations
  int          cyc_n = 0, irsp_cnt = 0, drsp_cnt = 0, mrv_cnt = 0;
  int          igrant_cyc = 0, irsp_cyc = 0;
  logic [31:0] irsp_data = 0, drsp_data = 0;
  byte         glog[$];
  string       exp_ord;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] rand_ia();
    return 32'h100 + ($urandom % 16) * 4;
  endfunction

  task automatic next_inst();
    case (imode)
      0: iv = 1'b0;
      1: begin iv = 1'b1; ia = rand_ia(); end
      default: begin iv = 1'($urandom % 2); ia = rand_ia(); end
    endcase
  endtask

  task automatic next_data();
    if (dmode == 0) dv = 1'b0;
    else begin
      dv = (dmode == 1) ? 1'b1 : 1'($urandom % 2);
      da = 32'h2000 + ($urandom % 16) * 4;
      dw = $urandom;
      ds = ($urandom % 2) ? 4'($urandom % 16) : 4'h0;
    end
  endtask

  task automatic clear_obs();
    irsp_cnt = 0; drsp_cnt = 0; mrv_cnt = 0;
    irsp_data = 0; drsp_data = 0;
    glog.delete();
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the model.
  task automatic cycle();
    logic exp_ird, exp_drd, dwin, exp_mrv;
    logic [31:0] old;
    if (imode == 2 && !iv && ($urandom % 3 == 0)) begin iv = 1'b1; ia = rand_ia(); end
    if (dmode == 2 && !dv && ($urandom % 3 == 0)) next_data();
    if (spur_rand != 0 && ($urandom % 8 == 0)) spur = 1'b1;
    inst_req_valid = iv; inst_req_addr = ia;
    data_req_valid = dv; data_req_addr = da; data_req_wdata = dw; data_req_wstrb = ds;
    if (busy && !accepted && hold_n > 0) begin
      mem_req_ready = 1'b0;
      hold_n--;
    end else mem_req_ready = (rdy_rand != 0) ? 1'($urandom % 2) : 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    if (busy && accepted) begin
      if (lat == 0) begin mem_rsp_valid = 1'b1; mem_rsp_data = pend_rdata; end
      else lat--;
    end else if (spur) begin
      mem_rsp_valid = 1'b1;
      spur = 1'b0;
    end
    #1;
    if (!reset) begin
      chk("reset_ctl", {inst_req_ready, data_req_ready, inst_rsp_valid, data_rsp_valid,
                        mem_req_valid, mem_req_wstrb}, 64'd0);
      chk("reset_addr_wdata", {mem_req_addr, mem_req_wdata}, 64'd0);
      chk("reset_rsp_data", {inst_rsp_data, data_rsp_data}, 64'd0);
      busy = 0; accepted = 0; rsp_due = 0; starve = 0; hold_n = 0; spur = 0;
    end else begin
      dwin    = !busy && dv && !(iv && starve == SM);
      exp_drd = dwin;
      exp_ird = !busy && iv && !dwin;
      exp_mrv = busy && !accepted;
      chk("inst_req_ready", inst_req_ready, exp_ird);
      chk("data_req_ready", data_req_ready, exp_drd);
      chk("mem_req_valid", mem_req_valid, exp_mrv);
      if (exp_mrv) begin
        chk("mem_req_addr", mem_req_addr, pend.a);
        chk("mem_req_wdata", mem_req_wdata, pend.w);
        chk("mem_req_wstrb", mem_req_wstrb, pend.s);
      end
      chk("inst_rsp_valid", inst_rsp_valid, rsp_due && !rsp_own_d);
      chk("data_rsp_valid", data_rsp_valid, rsp_due && rsp_own_d);
      if (rsp_due && !rsp_own_d) chk("inst_rsp_data", inst_rsp_data, rsp_dat);
      if (rsp_due && rsp_own_d)  chk("data_rsp_data", data_rsp_data, rsp_dat);
      if (!busy && !iv && !dv) begin
        chk("idle_zero", {mem_req_valid, inst_req_ready, data_req_ready,
                          mem_req_wstrb, mem_req_addr}, 64'd0);
        chk("idle_wdata", mem_req_wdata, 64'd0);
      end
      if (inst_req_ready) begin glog.push_back("I"); igrant_cyc = cyc_n; end
      if (data_req_ready) glog.push_back("D");
      if (inst_rsp_valid) begin irsp_cnt++; irsp_data = inst_rsp_data; irsp_cyc = cyc_n; end
      if (data_rsp_valid) begin drsp_cnt++; drsp_data = data_rsp_data; end
      if (mem_req_valid) mrv_cnt++;
      rsp_due = 1'b0;
      if (busy && accepted && mem_rsp_valid) begin
        rsp_due   = 1'b1;
        rsp_own_d = pend.own_d;
        rsp_dat   = (pend.s != 0) ? 32'd0 : mem_rsp_data;
        busy      = 1'b0;
      end else if (busy && !accepted && mem_req_ready) begin
        accepted = 1'b1;
        old = rd(pend.a);
        for (int b = 0; b < 4; b++)
          if (pend.s[b]) old[8*b +: 8] = pend.w[8*b +: 8];
        if (pend.s != 0) mem[pend.a] = old;
        pend_rdata = old;
        lat = (lat_cfg < 0) ? int'($urandom % 3) : lat_cfg;
      end
      if (exp_drd) begin
        busy = 1'b1; accepted = 1'b0;
        pend = '{own_d: 1'b1, a: da, w: dw, s: ds};
        if (iv) starve = (starve == SM) ? SM : starve + 1;
        next_data();
      end else if (exp_ird) begin
        busy = 1'b1; accepted = 1'b0;
        pend = '{own_d: 1'b0, a: ia, w: 32'd0, s: 4'd0};
        starve = 0;
        next_inst();
      end
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iv = 0; dv = 0;
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    inst_req_valid = 0; inst_req_addr = 0;
    data_req_valid = 0; data_req_addr = 0; data_req_wdata = 0; data_req_wstrb = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    exp_ord = "DDDDIDDDDI";
    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h180] = 32'hCAFE_F00D;
    @(negedge clk);
    // held in reset with requests pending: all outputs must stay low
    iv = 1; dv = 1; ia = 32'h100; da = 32'h2000;
    run(2);
    iv = 0; dv = 0;
    reset = 1'b1;

    // single fetch, granted in the first cycle after reset release
    clear_obs();
    iv = 1; ia = 32'h100; imode = 0;
    run(6);
    chk("fetch_rsp_count", irsp_cnt, 1);
    chk("fetch_rsp_data", irsp_data, 32'hDEAD_BEEF);
    chk("fetch_latency", irsp_cyc - igrant_cyc, 3);
    chk("fetch_no_data_rsp", drsp_cnt, 0);

    // simultaneous inst fetch and data store
    clear_obs();
    iv = 1; ia = 32'h104;
    dv = 1; da = 32'h2000; dw = 32'h1234; ds = 4'hF; dmode = 0;
    run(10);
    chk("simul_first_grant", glog[0], "D");
    chk("simul_second_grant", glog[1], "I");
    chk("simul_store_rsp_data", drsp_data, 32'd0);
    chk("simul_rsp_counts", {irsp_cnt[15:0], drsp_cnt[15:0]}, {16'd1, 16'd1});

    // continuous contention: starvation counter forces every fifth grant to inst
    do_reset();
    clear_obs();
    imode = 1; dmode = 1;
    iv = 1; ia = rand_ia(); next_data();
    for (int i = 0; i < 200 && glog.size() < 10; i++) cycle();
    chk("starve_grant_count", glog.size() >= 10, 1'b1);
    for (int k = 0; k < 10; k++) chk($sformatf("starve_order_%0d", k), glog[k], exp_ord[k]);
    imode = 0; dmode = 0; iv = 0; dv = 0;
    run(8);

    // memory backpressure for five cycles
    clear_obs();
    hold_n = 5;
    iv = 1; ia = 32'h108;
    run(12);
    chk("bp_mem_valid_cycles", mrv_cnt, 6);
    chk("bp_single_rsp", irsp_cnt, 1);

    // reset while waiting for memory, then a stale response after release
    lat_cfg = 5;
    iv = 1; ia = 32'h10C;
    run(4);
    chk("rst_mid_in_wait", accepted, 1'b1);
    clear_obs();
    do_reset();
    lat_cfg = 0;
    cycle();
    spur = 1;
    run(3);
    chk("rst_no_inst_rsp", irsp_cnt, 0);
    chk("rst_no_data_rsp", drsp_cnt, 0);
    clear_obs();
    iv = 1; ia = 32'h180;
    run(6);
    chk("rst_then_fetch", irsp_data, 32'hCAFE_F00D);

    // spurious memory response while idle
    clear_obs();
    spur = 1;
    run(2);
    chk("spur_no_rsp", irsp_cnt + drsp_cnt, 0);
    iv = 1; ia = 32'h100;
    run(6);
    chk("spur_fetch_rsp", irsp_cnt, 1);
    chk("spur_fetch_data", irsp_data, 32'hDEAD_BEEF);

    // random traffic with random backpressure, latency and spurious responses
    do_reset();
    imode = 2; dmode = 2; rdy_rand = 1; lat_cfg = -1; spur_rand = 1;
    run(3000);
    imode = 0; dmode = 0; iv = 0; dv = 0; spur_rand = 0; spur = 0;
    run(12);
    chk("random_drained", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
